// File: rtl/latch_glitch_filter.sv
// latch_glitch_filter
// Takes the asynchronous level from an upstream D latch and synchronises it
// into clk. Pulses shorter than STABLE_CYCLES synchronised samples are
// rejected. Outputs are a clean level, one-cycle rise/fall strobes and a
// saturating count of accepted transitions. Every output is registered, so
// there is no combinational path from d to any output.

module latch_glitch_filter #(
  parameter int STABLE_CYCLES = 4,  // consecutive samples needed, >= 2
  parameter int CNT_W         = 8   // width of edge_cnt
) (
  input  logic             clk,
  input  logic             rst,      // asynchronous, active-low
  input  logic             d,
  output logic             q_filt,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt
);

  // The stability counter only has to reach STABLE_CYCLES-1.
  localparam int            CW   = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    CHK_HIGH = 2'd1,
    ST_HIGH  = 2'd2,
    CHK_LOW  = 2'd3
  } state_t;

  state_t        state;
  logic          s1, s2;
  logic [CW-1:0] cnt;

  // Saturating increment: the count holds at all-ones and never wraps.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Two-flop synchroniser. Only s2 is used downstream.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments. With blocking
    // assignments s2 would see the new s1 in the same edge, and the two
    // flops would act as one.
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  // Qualification FSM. Outputs are registered and updated with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_LOW;
      cnt      <= '0;
      q_filt   <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
      busy     <= 1'b0;
      edge_cnt <= '0;
    end else begin
      // NOTE: the strobes default low on every edge. This keeps each one a
      // single-cycle pulse. Only the acceptance branches raise them.
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        ST_LOW: begin
          if (s2) begin
            state <= CHK_HIGH;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end
        end
        CHK_HIGH: begin
          if (!s2) begin
            state <= ST_LOW;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state    <= ST_HIGH;
            cnt      <= '0;
            busy     <= 1'b0;
            q_filt   <= 1'b1;
            rise     <= 1'b1;
            edge_cnt <= sat_inc(edge_cnt);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (!s2) begin
            state <= CHK_LOW;
            cnt   <= CW'(1);
            busy  <= 1'b1;
          end
        end
        CHK_LOW: begin
          if (s2) begin
            state <= ST_HIGH;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == LAST) begin
            state    <= ST_LOW;
            cnt      <= '0;
            busy     <= 1'b0;
            q_filt   <= 1'b0;
            fall     <= 1'b1;
            edge_cnt <= sat_inc(edge_cnt);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_LOW;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_latch_glitch_filter.sv
// tb_latch_glitch_filter
// Directed bench for latch_glitch_filter. One instance uses the default
// parameters. A second instance with CNT_W=2 exercises count saturation.
// Outputs are sampled 1 time unit after each rising clk edge.

module tb_latch_glitch_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d = 1'b0;
  logic       d_sat = 1'b0;

  logic       q_filt, rise, fall, busy;
  logic [7:0] edge_cnt;
  logic       q_filt_sat, rise_sat, fall_sat, busy_sat;
  logic [1:0] edge_cnt_sat;

  int checks = 0;
  int errors = 0;

  // Per-cycle logs of one directed sequence. Index i is the value after edge Ei.
  logic rise_log [16];
  logic fall_log [16];
  logic busy_log [16];
  logic q_log    [16];
  int   n_rise, n_fall;

  always #13 clk = ~clk;

  latch_glitch_filter dut (
    .clk      (clk),
    .rst      (rst),
    .d        (d),
    .q_filt   (q_filt),
    .rise     (rise),
    .fall     (fall),
    .busy     (busy),
    .edge_cnt (edge_cnt)
  );

  latch_glitch_filter #(.STABLE_CYCLES(4), .CNT_W(2)) dut_sat (
    .clk      (clk),
    .rst      (rst),
    .d        (d_sat),
    .q_filt   (q_filt_sat),
    .rise     (rise_sat),
    .fall     (fall_sat),
    .busy     (busy_sat),
    .edge_cnt (edge_cnt_sat)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive d to 'first' for n_first cycles, then to its inverse, for 'total' cycles.
  // Each new value is applied just after an edge, ahead of the next one.
  task automatic run_seq(input logic first, input int n_first, input int total);
    n_rise = 0;
    n_fall = 0;
    for (int i = 0; i < total; i++) begin
      d = (i < n_first) ? first : ~first;
      tick(1);
      rise_log[i] = rise;
      fall_log[i] = fall;
      busy_log[i] = busy;
      q_log[i]    = q_filt;
      if (rise) n_rise++;
      if (fall) n_fall++;
    end
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic prev_q;

    // ---- power-on reset ----
    #2 rst = 1'b0;
    #1;
    check("por_q_filt",   q_filt,   0);
    check("por_edge_cnt", edge_cnt, 0);
    check("por_busy",     busy,     0);
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rel_q_filt",   q_filt,   0);
    check("rel_busy",     busy,     0);
    check("rel_edge_cnt", edge_cnt, 0);

    // ---- clean rise ----
    run_seq(1'b1, 16, 16);
    check("rise_busy_e1",  busy_log[1], 0);
    check("rise_busy_e2",  busy_log[2], 1);
    check("rise_busy_e3",  busy_log[3], 1);
    check("rise_busy_e4",  busy_log[4], 1);
    check("rise_q_e4",     q_log[4],    0);
    check("rise_q_e5",     q_log[5],    1);
    check("rise_strobe_e5", rise_log[5], 1);
    check("rise_strobe_e6", rise_log[6], 0);
    check("rise_busy_e5",  busy_log[5], 0);
    check("rise_count",    n_rise,      1);
    check("rise_no_fall",  n_fall,      0);
    check("rise_edge_cnt", edge_cnt,    1);

    // ---- clean fall ----
    run_seq(1'b0, 16, 16);
    check("fall_strobe_e5", fall_log[5], 1);
    check("fall_strobe_e6", fall_log[6], 0);
    check("fall_q_e4",      q_log[4],    1);
    check("fall_count",     n_fall,      1);
    check("fall_no_rise",   n_rise,      0);
    check("fall_q_filt",    q_filt,      0);
    check("fall_edge_cnt",  edge_cnt,    2);

    // ---- glitch of STABLE_CYCLES-1 cycles is rejected ----
    run_seq(1'b1, 3, 16);
    check("glitch_busy_e2",  busy_log[2], 1);
    check("glitch_busy_e5",  busy_log[5], 0);
    check("glitch_no_rise",  n_rise,      0);
    check("glitch_q_filt",   q_filt,      0);
    check("glitch_edge_cnt", edge_cnt,    2);

    // ---- pulse of exactly STABLE_CYCLES cycles is accepted ----
    // The fall candidate starts on the edge right after the rise strobe.
    run_seq(1'b1, 4, 16);
    check("exact_rise_e5",  rise_log[5], 1);
    check("exact_q_e5",     q_log[5],    1);
    check("exact_busy_e6",  busy_log[6], 1);
    check("exact_fall_e9",  fall_log[9], 1);
    check("exact_n_rise",   n_rise,      1);
    check("exact_n_fall",   n_fall,      1);
    check("exact_q_filt",   q_filt,      0);
    check("exact_edge_cnt", edge_cnt,    4);

    // ---- asynchronous reset mid-cycle ----
    run_seq(1'b1, 8, 8);
    check("pre_rst_q_filt",   q_filt,   1);
    check("pre_rst_edge_cnt", edge_cnt, 5);
    #5 rst = 1'b0;
    #1;  // still well before the next clk edge
    check("arst_q_filt",   q_filt,   0);
    check("arst_rise",     rise,     0);
    check("arst_fall",     fall,     0);
    check("arst_busy",     busy,     0);
    check("arst_edge_cnt", edge_cnt, 0);
    tick(2);
    check("arst_hold_q",   q_filt,   0);
    check("arst_hold_cnt", edge_cnt, 0);
    d = 1'b0;
    rst = 1'b1;
    tick(3);

    // ---- reset during qualification ----
    d = 1'b1;
    tick(4);
    check("mid_busy_e3", busy, 1);
    rst = 1'b0;
    #1;
    check("mid_busy_rst", busy, 0);
    check("mid_rise_rst", rise, 0);
    tick(2);
    check("mid_rise_hold", rise,     0);
    check("mid_cnt_hold",  edge_cnt, 0);
    rst = 1'b1;
    n_rise = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      q_log[i]    = q_filt;
      rise_log[i] = rise;
      if (rise) n_rise++;
    end
    check("mid_q_r5",     q_log[4],    0);
    check("mid_q_r6",     q_log[5],    1);
    check("mid_rise_r6",  rise_log[5], 1);
    check("mid_n_rise",   n_rise,      1);
    check("mid_edge_cnt", edge_cnt,    1);

    // ---- saturation with CNT_W=2 ----
    for (int k = 0; k < 5; k++) begin
      d_sat = ~d_sat;
      tick(8);
      check("sat_edge_cnt", edge_cnt_sat, (k < 3) ? k + 1 : 3);
      check("sat_q_filt",   q_filt_sat,   d_sat);
    end

    // ---- d toggling faster than clk ----
    prev_q = q_filt;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          d = 1'($urandom_range(0, 1));
          #2;
        end
      end
      begin
        for (int i = 0; i < 20; i++) begin
          tick(1);
          check("rnd_rise", rise, q_filt & ~prev_q);
          check("rnd_fall", fall, ~q_filt & prev_q);
          prev_q = q_filt;
        end
      end
    join
    check("rnd_settle", q_filt, d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
